// File: rtl/jelly2_fifo_read_stream.sv
`default_nettype none
// ============================================================================
//  Module   : jelly2_fifo_read_stream
//  Purpose  : Read-side adapter for jelly2_fifo. Issues FIFO reads on a
//             credit basis and hides the RAM read latency (1 + DOUT_REGS
//             cycles) behind a small circular skid buffer. The buffered words
//             are presented downstream as a valid/ready stream.
//
//  Ports    : reset        async active-high reset
//             clk          clock
//             cke          clock enable (all state holds when 0)
//             s_empty      FIFO empty flag
//             s_rd_en      FIFO read request
//             s_rd_regcke  FIFO output-register enable
//             s_rd_data    FIFO read data
//             m_data       stream data (straight from the buffer registers)
//             m_valid      stream valid
//             m_ready      stream ready
//             buf_count    words currently held in the skid buffer
//
//  Options  : define JELLY2_FIFO_READ_STREAM_ASSERT_EN to compile in
//             simulation-only immediate assertions.
//
//  Revision : 1.0  initial release
// ============================================================================
module jelly2_fifo_read_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DOUT_REGS  = 0
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,

  input  logic                  s_empty,
  output logic                  s_rd_en,
  output logic                  s_rd_regcke,
  input  logic [DATA_WIDTH-1:0] s_rd_data,

  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2:0]            buf_count
);

  localparam int LATENCY   = 1 + DOUT_REGS;
  localparam int BUF_DEPTH = LATENCY + 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(BUF_DEPTH - 1);
  localparam logic [3:0]       DEPTH_CREDIT = 4'(BUF_DEPTH);
  localparam logic [2:0]       DEPTH_COUNT  = 3'(BUF_DEPTH);

  // Bit i set means a read issued i+1 enabled cycles ago is still on its way;
  // the top bit marks the word currently present on s_rd_data.
  logic [LATENCY-1:0]    r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [0:BUF_DEPTH-1];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [2:0]            r_count;

  logic [3:0]            w_inflight_cnt;
  logic [3:0]            w_credit_used;
  logic                  w_push;
  logic                  w_pop;

  // Pointers wrap at BUF_DEPTH, which is generally not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + 4'(r_inflight[i]);
    end
  end

  // Every issued read already owns a buffer slot, so an arriving word can
  // always be stored. Pops are deliberately not credited here, which keeps
  // m_ready out of the s_rd_en path.
  assign w_credit_used = {1'b0, r_count} + w_inflight_cnt;
  assign s_rd_en       = ~reset & cke & ~s_empty & (w_credit_used < DEPTH_CREDIT);
  assign s_rd_regcke   = cke;

  assign w_push    = cke & r_inflight[LATENCY-1];
  assign w_pop     = cke & m_valid & m_ready;

  assign m_valid   = (r_count != 3'd0);
  assign m_data    = r_buf[r_head];
  assign buf_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (cke) begin
      r_inflight <= (r_inflight << 1) | LATENCY'(s_rd_en);

      if (w_push) begin
        r_buf[r_tail] <= s_rd_data;
        r_tail        <= ptr_inc(r_tail);
      end

      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef JELLY2_FIFO_READ_STREAM_ASSERT_EN
  // Output snapshot from the previous edge, used for the stall stability check.
  logic                  r_chk_hold;
  logic [DATA_WIDTH-1:0] r_chk_data;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && (r_count == DEPTH_COUNT)))
        else $error("push into a full skid buffer");
      if (r_chk_hold) begin
        assert (m_valid && (m_data == r_chk_data))
          else $error("stream output changed while stalled");
      end
      assert (w_credit_used <= DEPTH_CREDIT)
        else $error("buffered plus in-flight words exceed buffer depth");
      assert (!(s_rd_en && s_empty))
        else $error("read issued while FIFO empty");
    end
    r_chk_hold <= !reset && m_valid && !(m_ready && cke);
    r_chk_data <= m_data;
  end
`endif

endmodule
`default_nettype wire
